// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
//   DATA_W / ADDR_W / BE_W : bus widths (32-bit data, 32-bit byte address, 4 byte enables)
//   dmem_state_t           : responder FSM states
//   dmem_req_t             : captured request (write flag, address, store data, byte enables)
//   word_index()           : byte address -> word index relative to a base, modulo 2^32
// Optional feature macro used by the responder: DMEM_ERR_CHECK_EN.
package dmem_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } dmem_req_t;

    // Subtraction wraps naturally at 32 bits, so addresses below the base map to huge indices.
    function automatic logic [ADDR_W-1:0] word_index(input logic [ADDR_W-1:0] addr,
                                                     input logic [ADDR_W-1:0] base);
        return (addr - base) >> 2;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Data-memory request/response bus between the core (master) and the memory (slave).
//   req_valid/req_ready : request handshake; req_write, req_addr, req_wdata, req_be carry the request
//   rsp_valid/rsp_ready : response handshake; rsp_rdata, rsp_err carry the response
interface dmem_responder_if;
    import dmem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_array.sv
// DEPTH_WORDS x 32-bit storage with per-byte write enables and a registered read port.
//   clk, reset : clock and asynchronous active-low reset (read register only; storage is not reset)
//   en_i       : access strobe; the single edge on which a write lands and a read is sampled
//   re_i       : read valid; when low the read register is loaded with zero instead of array data
//   we_i       : per-byte write enables (only honoured with en_i)
//   addr_i     : word index
//   wdata_i    : store data
//   rdata_o    : read register, stable between access strobes
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           en_i,
    input  logic                           re_i,
    input  logic [BE_W-1:0]                we_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
    input  logic [DATA_W-1:0]              wdata_i,
    output logic [DATA_W-1:0]              rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
    logic [DATA_W-1:0] rdata_q;

    // Byte-granular store on the access strobe.
    always_ff @(posedge clk) begin
        if (en_i) begin
            for (int b = 0; b < BE_W; b++) begin
                if (we_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Read register: zero for stores and rejected loads so the response data needs no extra gating.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= {DATA_W{1'b0}};
        end else if (en_i) begin
            rdata_q <= re_i ? mem_q[addr_i] : {DATA_W{1'b0}};
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the core data bus: accepts one load/store at a time, waits a fixed
// latency, commits to / reads from dmem_array, and holds the response until the core takes it.
//   clk, reset : clock and asynchronous active-low reset
//   bus        : dmem_responder_if.slave (request and response channels)
// Timing: a request accepted on edge N commits and enters RESP on edge N+LATENCY-1, so rsp_valid is
// seen in the LATENCY-th cycle counting the accept cycle; issue interval is LATENCY+1 cycles.
// Optional macro DMEM_ERR_CHECK_EN: flag misaligned or out-of-range accesses on rsp_err and suppress
// them; without it rsp_err is 0, the low address bits are ignored and out-of-range accesses are
// silently dropped (loads return 0).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned       DEPTH_WORDS = 256,
    parameter int unsigned       LATENCY     = 2,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus
);

    localparam int unsigned IDX_W        = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT     = (LATENCY >= 32'd2) ? 4'(LATENCY - 32'd2) : 4'd0;
    localparam logic        SINGLE_CYCLE = (LATENCY == 32'd1);

    dmem_state_t       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    dmem_req_t         req_q, req_d, live_s, cur_s;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic              accept_s, rsp_done_s, commit_s;
    logic              in_range_s, err_s, ok_s, re_s;
    logic [BE_W-1:0]   we_s;
    logic [ADDR_W-1:0] word_s;
    logic [DATA_W-1:0] rdata_s;

    assign live_s     = '{bus.req_write, bus.req_addr, bus.req_wdata, bus.req_be};
    assign accept_s   = bus.req_valid & req_ready_q;
    assign rsp_done_s = rsp_valid_q & bus.rsp_ready;

    // With LATENCY==1 the commit edge is the accept edge, before the request register holds anything,
    // so the array is fed straight from the bus while idle.
    assign cur_s    = (state_q == IDLE) ? live_s : req_q;
    assign commit_s = ((state_q == IDLE) & accept_s & SINGLE_CYCLE)
                    | ((state_q == WAIT) & (cnt_q == 4'd0));

    assign word_s     = word_index(cur_s.addr, BASE_ADDR);
    assign in_range_s = (word_s < 32'(DEPTH_WORDS));
`ifdef DMEM_ERR_CHECK_EN
    assign err_s = ~in_range_s | (cur_s.addr[1:0] != 2'b00);
`else
    assign err_s = 1'b0;
`endif
    assign ok_s = in_range_s & ~err_s;
    assign re_s = ~cur_s.write & ok_s;
    assign we_s = (cur_s.write & ok_s) ? cur_s.be : 4'b0000;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .en_i    (commit_s),
        .re_i    (re_s),
        .we_i    (we_s),
        .addr_i  (word_s[IDX_W-1:0]),
        .wdata_i (cur_s.wdata),
        .rdata_o (rdata_s)
    );

    // Next-state and latency counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    if (SINGLE_CYCLE) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_done_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Request register captures the bus on accept only.
    always_comb begin
        if (accept_s) begin
            req_d = live_s;
        end else begin
            req_d = req_q;
        end
    end

    // Output decode from the next state so the handshake outputs come straight from flops.
    always_comb begin
        req_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        case (state_d)
            IDLE: req_ready_d = 1'b1;
            WAIT: req_ready_d = 1'b0;
            RESP: begin
                rsp_valid_d = 1'b1;
                if (commit_s) begin
                    rsp_err_d = err_s;
                end else begin
                    rsp_err_d = rsp_err_q;
                end
            end
            default: req_ready_d = 1'b0;
        endcase
    end

    // State, counter, request and response registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            req_q       <= {$bits(dmem_req_t){1'b0}};
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rdata_s;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder. Three instances share clock and reset:
//   index 0: LATENCY=2, index 1: LATENCY=4, index 2: LATENCY=1 (all DEPTH_WORDS=256, BASE_ADDR=0).
// Inputs are driven and outputs sampled on the falling edge.
module tb_dmem_responder;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

`ifdef DMEM_ERR_CHECK_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic        req_valid_t [3];
    logic        req_write_t [3];
    logic [31:0] req_addr_t  [3];
    logic [31:0] req_wdata_t [3];
    logic [3:0]  req_be_t    [3];
    logic        rsp_ready_t [3];
    logic        req_ready_t [3];
    logic        rsp_valid_t [3];
    logic [31:0] rsp_rdata_t [3];
    logic        rsp_err_t   [3];

    int n_tests = 0;
    int n_fail  = 0;

    dmem_responder_if bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_wire
        assign bus[g].req_valid = req_valid_t[g];
        assign bus[g].req_write = req_write_t[g];
        assign bus[g].req_addr  = req_addr_t[g];
        assign bus[g].req_wdata = req_wdata_t[g];
        assign bus[g].req_be    = req_be_t[g];
        assign bus[g].rsp_ready = rsp_ready_t[g];
        assign req_ready_t[g]   = bus[g].req_ready;
        assign rsp_valid_t[g]   = bus[g].rsp_valid;
        assign rsp_rdata_t[g]   = bus[g].rsp_rdata;
        assign rsp_err_t[g]     = bus[g].rsp_err;
    end

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2), .BASE_ADDR(32'h0)) u_l2 (.clk(clk), .reset(rst_n), .bus(bus[0]));
    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(4), .BASE_ADDR(32'h0)) u_l4 (.clk(clk), .reset(rst_n), .bus(bus[1]));
    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1), .BASE_ADDR(32'h0)) u_l1 (.clk(clk), .reset(rst_n), .bus(bus[2]));

    // One complete transaction on instance k; starts and ends on a falling edge with the DUT idle.
    // lat = falling edges from the accept edge up to the first one showing rsp_valid (40 = timed out).
    task automatic transact(input int k, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [3:0] be,
                            output logic [31:0] rd, output logic er, output int lat);
        req_valid_t[k] = 1'b1;
        req_write_t[k] = wr;
        req_addr_t[k]  = addr;
        req_wdata_t[k] = wd;
        req_be_t[k]    = be;
        rsp_ready_t[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid_t[k] = 1'b0;
        lat = 1;
        while (rsp_valid_t[k] !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        rd = rsp_rdata_t[k];
        er = rsp_err_t[k];
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (req_ready_t[k] !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready[%0d]: got %b expected 1", k, req_ready_t[k]); end
            n_tests++;
            if (rsp_valid_t[k] !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid[%0d]: got %b expected 0", k, rsp_valid_t[k]); end
            n_tests++;
            if (rsp_rdata_t[k] !== 32'h0) begin n_fail++; $display("FAIL reset_rdata[%0d]: got %h expected 0", k, rsp_rdata_t[k]); end
            n_tests++;
            if (rsp_err_t[k] !== 1'b0) begin n_fail++; $display("FAIL reset_err[%0d]: got %b expected 0", k, rsp_err_t[k]); end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er; int lat;
        transact(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
        n_tests++;
        if (lat !== 2) begin n_fail++; $display("FAIL store_latency: got %0d expected 2", lat); end
        n_tests++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL store_rdata: got %h expected 00000000", rd); end
        n_tests++;
        if (er !== 1'b0) begin n_fail++; $display("FAIL store_err: got %b expected 0", er); end
        transact(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        n_tests++;
        if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL load_rdata: got %h expected deadbeef", rd); end
        n_tests++;
        if (lat !== 2) begin n_fail++; $display("FAIL load_latency: got %0d expected 2", lat); end
    endtask

    task automatic test_byte_enable();
        logic [31:0] rd; logic er; int lat;
        transact(0, 1'b1, 32'h10, 32'h0000_AA00, 4'h2, rd, er, lat);
        transact(0, 1'b0, 32'h10, 32'hFFFF_FFFF, 4'h0, rd, er, lat);
        n_tests++;
        if (rd !== 32'hDEAD_AAEF) begin n_fail++; $display("FAIL byte_enable: got %h expected deadaaef", rd); end
        // Store with no byte enables: acknowledged, nothing written.
        transact(0, 1'b1, 32'h10, 32'h1234_5678, 4'h0, rd, er, lat);
        n_tests++;
        if (lat !== 2) begin n_fail++; $display("FAIL be0_ack_latency: got %0d expected 2", lat); end
        transact(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        n_tests++;
        if (rd !== 32'hDEAD_AAEF) begin n_fail++; $display("FAIL be0_no_write: got %h expected deadaaef", rd); end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er; int lat;
        req_valid_t[0] = 1'b1; req_write_t[0] = 1'b0; req_addr_t[0] = 32'h10;
        req_be_t[0] = 4'h0; rsp_ready_t[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        lat = 1;
        while (rsp_valid_t[0] !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
        n_tests++;
        if (lat !== 2) begin n_fail++; $display("FAIL bp_latency: got %0d expected 2", lat); end
        // A competing store is presented while the response is stalled; it must be ignored.
        req_write_t[0] = 1'b1; req_wdata_t[0] = 32'h0; req_be_t[0] = 4'hF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++;
            if (rsp_valid_t[0] !== 1'b1 || rsp_rdata_t[0] !== 32'hDEAD_AAEF || req_ready_t[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got valid=%b rdata=%h ready=%b expected 1 deadaaef 0",
                         i, rsp_valid_t[0], rsp_rdata_t[0], req_ready_t[0]);
            end
        end
        req_valid_t[0] = 1'b0; rsp_ready_t[0] = 1'b1;
        @(negedge clk);
        n_tests++;
        if (rsp_valid_t[0] !== 1'b0 || req_ready_t[0] !== 1'b1) begin
            n_fail++; $display("FAIL bp_release: got valid=%b ready=%b expected 0 1", rsp_valid_t[0], req_ready_t[0]);
        end
        @(negedge clk);
        n_tests++;
        if (rsp_valid_t[0] !== 1'b0) begin n_fail++; $display("FAIL bp_no_extra_rsp: got %b expected 0", rsp_valid_t[0]); end
        transact(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        n_tests++;
        if (rd !== 32'hDEAD_AAEF) begin n_fail++; $display("FAIL bp_ignored_store: got %h expected deadaaef", rd); end
    endtask

    task automatic test_range_align();
        logic [31:0] rd; logic er; int lat;
        transact(0, 1'b1, 32'h0, 32'hA5A5_A5A5, 4'hF, rd, er, lat);
        transact(0, 1'b1, 32'h400, 32'h1234_5678, 4'hF, rd, er, lat);
        n_tests++;
        if (lat !== 2) begin n_fail++; $display("FAIL oor_store_ack: got latency %0d expected 2", lat); end
        n_tests++;
        if (er !== ERR_EN) begin n_fail++; $display("FAIL oor_store_err: got %b expected %b", er, ERR_EN); end
        transact(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
        n_tests++;
        if (rd !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL oor_no_write: got %h expected a5a5a5a5", rd); end
        transact(0, 1'b0, 32'h400, 32'h0, 4'h0, rd, er, lat);
        n_tests++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL oor_load_rdata: got %h expected 00000000", rd); end
        transact(0, 1'b0, 32'h12, 32'h0, 4'h0, rd, er, lat);
        n_tests++;
        if (er !== ERR_EN) begin n_fail++; $display("FAIL misalign_err: got %b expected %b", er, ERR_EN); end
        n_tests++;
        if (rd !== (ERR_EN ? 32'h0 : 32'hDEAD_AAEF)) begin
            n_fail++; $display("FAIL misalign_rdata: got %h expected %h", rd, ERR_EN ? 32'h0 : 32'hDEAD_AAEF);
        end
    endtask

    task automatic test_reset_mid_txn();
        logic [31:0] rd; logic er; int lat; int seen;
        transact(1, 1'b1, 32'h20, 32'h1111_2222, 4'hF, rd, er, lat);
        n_tests++;
        if (lat !== 4) begin n_fail++; $display("FAIL l4_latency: got %0d expected 4", lat); end
        req_valid_t[1] = 1'b1; req_write_t[1] = 1'b1; req_addr_t[1] = 32'h20;
        req_wdata_t[1] = 32'h5555_5555; req_be_t[1] = 4'hF; rsp_ready_t[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid_t[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (req_ready_t[1] !== 1'b1 || rsp_valid_t[1] !== 1'b0 || rsp_rdata_t[1] !== 32'h0 || rsp_err_t[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got ready=%b valid=%b rdata=%h err=%b expected 1 0 00000000 0",
                     req_ready_t[1], rsp_valid_t[1], rsp_rdata_t[1], rsp_err_t[1]);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid_t[1] === 1'b1) seen++;
        end
        n_tests++;
        if (seen !== 0) begin n_fail++; $display("FAIL midreset_no_rsp: got %0d responses expected 0", seen); end
        transact(1, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        n_tests++;
        if (rd !== 32'h1111_2222) begin n_fail++; $display("FAIL midreset_mem: got %h expected 11112222", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int lat;
        logic [31:0] exp_w [3];
        exp_w[0] = 32'h1000_0001; exp_w[1] = 32'h2000_0002; exp_w[2] = 32'h3000_0003;
        for (int i = 0; i < 3; i++) begin
            transact(2, 1'b1, 32'(4 * i), exp_w[i], 4'hF, rd, er, lat);
        end
        n_tests++;
        if (lat !== 1) begin n_fail++; $display("FAIL l1_latency: got %0d expected 1", lat); end
        req_valid_t[2] = 1'b1; req_write_t[2] = 1'b0; rsp_ready_t[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_addr_t[2] = 32'(4 * i);
            n_tests++;
            if (req_ready_t[2] !== 1'b1 || rsp_valid_t[2] !== 1'b0) begin
                n_fail++; $display("FAIL b2b_idle[%0d]: got ready=%b valid=%b expected 1 0", i, req_ready_t[2], rsp_valid_t[2]);
            end
            @(negedge clk);
            n_tests++;
            if (rsp_valid_t[2] !== 1'b1 || rsp_rdata_t[2] !== exp_w[i]) begin
                n_fail++; $display("FAIL b2b_rsp[%0d]: got valid=%b rdata=%h expected 1 %h", i, rsp_valid_t[2], rsp_rdata_t[2], exp_w[i]);
            end
            @(negedge clk);
        end
        req_valid_t[2] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            req_valid_t[k] = 1'b0; req_write_t[k] = 1'b0; req_addr_t[k] = 32'h0;
            req_wdata_t[k] = 32'h0; req_be_t[k] = 4'h0; rsp_ready_t[k] = 1'b1;
        end
        test_reset();
        test_store_load();
        test_byte_enable();
        test_backpressure();
        test_range_align();
        test_reset_mid_txn();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
